// File: rtl/fft_pkg.sv
// Fixed-point constants and the shared rescale helper used by the complex
// multiplier and the FFT butterfly.
package fft_pkg;

  localparam int ROUND_TRUNC  = 0;
  localparam int ROUND_HALFUP = 1;
  localparam int SAT_WRAP     = 0;
  localparam int SAT_CLAMP    = 1;

  localparam int FX_MAX_WL = 32;
  localparam int FX_SUM_W  = 2*FX_MAX_WL + 2;

  typedef logic signed [FX_SUM_W-1:0] fx_sum_t;
  typedef logic [FX_MAX_WL:0]         fx_res_t;

  // Returns {ovf, value}; value occupies the low wl bits, upper bits are zero.
  function automatic fx_res_t fx_rescale(input fx_sum_t sum, input int wl,
                                         input int rnd, input int sat);
    fx_sum_t biased;
    fx_sum_t shifted;
    fx_sum_t vmax;
    fx_sum_t vmin;
    fx_sum_t val;
    logic    ovf;
    fx_res_t res;
    biased = sum;
    if (rnd == ROUND_HALFUP)
      biased = sum + (fx_sum_t'(1) <<< (wl-2));
    shifted = biased >>> (wl-1);
    vmax    = (fx_sum_t'(1) <<< (wl-1)) - fx_sum_t'(1);
    vmin    = -(fx_sum_t'(1) <<< (wl-1));
    ovf     = (shifted > vmax) || (shifted < vmin);
    val     = shifted;
    if ((sat == SAT_CLAMP) && ovf)
      val = (shifted > vmax) ? vmax : vmin;
    res = '0;
    res[FX_MAX_WL] = ovf;
    for (int k = 0; k < FX_MAX_WL; k++)
      if (k < wl) res[k] = val[k];
    return res;
  endfunction

endpackage

// File: rtl/cmult_rescale.sv
// Rescale stage of the complex multiplier: shift a 2WL+1-bit exact sum back
// to Q1.(WL-1), round, then saturate or wrap and flag overflow.
module cmult_rescale
  import fft_pkg::*;
#(
  parameter int WL    = 16,
  parameter int ROUND = ROUND_HALFUP,
  parameter int SAT   = SAT_CLAMP
) (
  input  logic signed [2*WL:0]  i_sum,
  output logic signed [WL-1:0]  o_val,
  output logic                  o_ovf
);

  fx_sum_t w_sum;

  assign w_sum = fx_sum_t'(i_sum);
  assign o_val = WL'(fx_rescale(w_sum, WL, ROUND, SAT));
  assign o_ovf = 1'(fx_rescale(w_sum, WL, ROUND, SAT) >> FX_MAX_WL);

endmodule

// File: rtl/complex_mult_pipe.sv
// Four-stage pipelined complex multiplier, out = a*b or a*conj(b), with a
// single global enable for valid/ready back-pressure.
module complex_mult_pipe
  import fft_pkg::*;
#(
  parameter int WL    = 16,
  parameter int ROUND = ROUND_HALFUP,
  parameter int SAT   = SAT_CLAMP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WL-1:0] a_r,
  input  logic signed [WL-1:0] a_i,
  input  logic signed [WL-1:0] b_r,
  input  logic signed [WL-1:0] b_i,
  input  logic                 conj_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] out_r,
  output logic signed [WL-1:0] out_i,
  output logic                 out_ovf
);

  logic w_en;

  logic r_vld_p1;
  logic r_vld_p2;
  logic r_vld_p3;

  logic signed [WL-1:0]   r_ar_p1, r_ai_p1, r_br_p1, r_bi_p1;
  logic                   r_conj_p1;
  logic signed [2*WL-1:0] r_rr_p2, r_ii_p2, r_ri_p2, r_ir_p2;
  logic                   r_conj_p2;
  logic signed [2*WL:0]   r_re_p3, r_im_p3;

  logic signed [2*WL-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [2*WL:0]   w_rr_x, w_ii_x, w_ri_x, w_ir_x;
  logic signed [WL-1:0]   w_re_q, w_im_q;
  logic                   w_re_ovf, w_im_ovf;

  // The whole pipe stalls only when a result is waiting and not taken.
  assign w_en     = out_ready || !out_valid;
  assign in_ready = w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_ovf   <= 1'b0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      r_vld_p3  <= r_vld_p2;
      out_valid <= r_vld_p3;
      out_r     <= w_re_q;
      out_i     <= w_im_q;
      out_ovf   <= w_re_ovf | w_im_ovf;
    end
  end

  // ---- S1: operand capture ----
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_ar_p1   <= a_r;
      r_ai_p1   <= a_i;
      r_br_p1   <= b_r;
      r_bi_p1   <= b_i;
      r_conj_p1 <= conj_b;
    end
  end

  // ---- S2: four full-width signed products ----
  assign w_ar_x = $signed({{WL{r_ar_p1[WL-1]}}, r_ar_p1});
  assign w_ai_x = $signed({{WL{r_ai_p1[WL-1]}}, r_ai_p1});
  assign w_br_x = $signed({{WL{r_br_p1[WL-1]}}, r_br_p1});
  assign w_bi_x = $signed({{WL{r_bi_p1[WL-1]}}, r_bi_p1});

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_rr_p2   <= w_ar_x * w_br_x;
      r_ii_p2   <= w_ai_x * w_bi_x;
      r_ri_p2   <= w_ar_x * w_bi_x;
      r_ir_p2   <= w_ai_x * w_br_x;
      r_conj_p2 <= r_conj_p1;
    end
  end

  // ---- S3: exact sums; conj swaps add/sub so b_i is never negated ----
  assign w_rr_x = $signed({r_rr_p2[2*WL-1], r_rr_p2});
  assign w_ii_x = $signed({r_ii_p2[2*WL-1], r_ii_p2});
  assign w_ri_x = $signed({r_ri_p2[2*WL-1], r_ri_p2});
  assign w_ir_x = $signed({r_ir_p2[2*WL-1], r_ir_p2});

  always_ff @(posedge clk) begin
    if (w_en) begin
      if (r_conj_p2) begin
        r_re_p3 <= w_rr_x + w_ii_x;
        r_im_p3 <= w_ir_x - w_ri_x;
      end else begin
        r_re_p3 <= w_rr_x - w_ii_x;
        r_im_p3 <= w_ri_x + w_ir_x;
      end
    end
  end

  // ---- S4: rescale into the output registers ----
  cmult_rescale #(.WL(WL), .ROUND(ROUND), .SAT(SAT)) u_rescale_re (
    .i_sum (r_re_p3),
    .o_val (w_re_q),
    .o_ovf (w_re_ovf)
  );

  cmult_rescale #(.WL(WL), .ROUND(ROUND), .SAT(SAT)) u_rescale_im (
    .i_sum (r_im_p3),
    .o_val (w_im_q),
    .o_ovf (w_im_ovf)
  );

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: a round/saturate instance and a truncate/wrap
// instance share stimulus and are scored against an integer reference model.
module tb_complex_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic        conj_b = 1'b0;

  logic        in_ready1, out_valid1, out_ovf1;
  logic [15:0] out_r1, out_i1;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_r2, out_i2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc1  = 0;
  int n_pop1  = 0;
  int n_acc2  = 0;
  int n_pop2  = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  complex_mult_pipe #(.WL(16), .ROUND(1), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .conj_b(conj_b),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_r(out_r1), .out_i(out_i1), .out_ovf(out_ovf1)
  );

  complex_mult_pipe #(.WL(16), .ROUND(0), .SAT(0)) u_dut_tw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .conj_b(conj_b),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_r(out_r2), .out_i(out_i2), .out_ovf(out_ovf2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact product in plain integers, then scale by 2^-15 with floor/round.
  function automatic void scale(input longint s, input bit rnd, input bit sat,
                                output logic [15:0] v, output logic ovf);
    longint t;
    t   = (s + (rnd ? 64'sd16384 : 64'sd0)) >>> 15;
    ovf = (t > 32767) || (t < -32768);
    if (sat && t > 32767)       t = 32767;
    else if (sat && t < -32768) t = -32768;
    v = t[15:0];
  endfunction

  function automatic exp_t model(input logic [15:0] ar, ai, br, bi, input logic cj,
                                 input bit rnd, input bit sat);
    longint sar, sai, sbr, sbi, re, im;
    exp_t   e;
    logic   o_re, o_im;
    sar = longint'($signed(ar));
    sai = longint'($signed(ai));
    sbr = longint'($signed(br));
    sbi = cj ? -longint'($signed(bi)) : longint'($signed(bi));
    re  = sar*sbr - sai*sbi;
    im  = sar*sbi + sai*sbr;
    scale(re, rnd, sat, e.r, o_re);
    scale(im, rnd, sat, e.i, o_im);
    e.ovf = o_re | o_im;
    return e;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic        stall1 = 1'b0, stall2 = 1'b0;
  logic [16:0] prev1, prev2;
  always @(negedge clk) begin
    check("in_ready1", {31'd0, in_ready1}, {31'd0, out_ready || !out_valid1});
    check("in_ready2", {31'd0, in_ready2}, {31'd0, out_ready || !out_valid2});
    if (stall1) check("hold1", {15'd0, out_ovf1, out_r1}, {15'd0, prev1});
    if (stall2) check("hold2", {15'd0, out_ovf2, out_r2}, {15'd0, prev2});
    if (out_valid1) begin
      if (q1.size() == 0) check("spurious1", 32'd1, 32'd0);
      else begin
        check("res1.r",   {16'd0, out_r1}, {16'd0, q1[0].r});
        check("res1.i",   {16'd0, out_i1}, {16'd0, q1[0].i});
        check("res1.ovf", {31'd0, out_ovf1}, {31'd0, q1[0].ovf});
      end
    end
    if (out_valid2) begin
      if (q2.size() == 0) check("spurious2", 32'd1, 32'd0);
      else begin
        check("res2.r",   {16'd0, out_r2}, {16'd0, q2[0].r});
        check("res2.i",   {16'd0, out_i2}, {16'd0, q2[0].i});
        check("res2.ovf", {31'd0, out_ovf2}, {31'd0, q2[0].ovf});
      end
    end
    if (rst) begin
      q1.delete();
      q2.delete();
      stall1 = 1'b0;
      stall2 = 1'b0;
    end else begin
      if (out_valid1 && out_ready && q1.size() > 0) begin void'(q1.pop_front()); n_pop1++; end
      if (out_valid2 && out_ready && q2.size() > 0) begin void'(q2.pop_front()); n_pop2++; end
      if (in_valid && in_ready1) begin
        q1.push_back(model(a_r, a_i, b_r, b_i, conj_b, 1'b1, 1'b1));
        n_acc1++;
      end
      if (in_valid && in_ready2) begin
        q2.push_back(model(a_r, a_i, b_r, b_i, conj_b, 1'b0, 1'b0));
        n_acc2++;
      end
      stall1 = out_valid1 && !out_ready;
      stall2 = out_valid2 && !out_ready;
      prev1  = {out_ovf1, out_r1};
      prev2  = {out_ovf2, out_r2};
    end
  end

  task automatic directed(input string nm, input logic [15:0] ar, ai, br, bi, input logic cj,
                          input logic [15:0] er, ei, input logic eo,
                          input logic [15:0] er2, ei2, input logic eo2);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    a_r = ar; a_i = ai; b_r = br; b_i = bi; conj_b = cj;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, ".latency"}, lat, 4);
    check({nm, ".r"},    {16'd0, out_r1}, {16'd0, er});
    check({nm, ".i"},    {16'd0, out_i1}, {16'd0, ei});
    check({nm, ".ovf"},  {31'd0, out_ovf1}, {31'd0, eo});
    check({nm, ".tw.r"}, {16'd0, out_r2}, {16'd0, er2});
    check({nm, ".tw.i"}, {16'd0, out_i2}, {16'd0, ei2});
    check({nm, ".tw.ovf"}, {31'd0, out_ovf2}, {31'd0, eo2});
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    int start;
    int nv;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", {31'd0, out_valid1}, 32'd0);
    check("rst.out_r",     {16'd0, out_r1}, 32'd0);
    check("rst.out_i",     {16'd0, out_i1}, 32'd0);
    check("rst.out_ovf",   {31'd0, out_ovf1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready",  {31'd0, in_ready1}, 32'd1);

    directed("half_sq",  16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0,
             16'h2000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0);
    directed("cplx",     16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0,
             16'h4000, 16'h0000, 1'b0, 16'h4000, 16'h0000, 1'b0);
    directed("cplx_conj", 16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b1,
             16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h4000, 1'b0);
    directed("neg_one_sq", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0,
             16'h7FFF, 16'h0000, 1'b1, 16'h8000, 16'h0000, 1'b1);
    directed("round_pos", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0,
             16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    directed("round_neg", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0,
             16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    directed("conj_min_bi", 16'h4000, 16'h0000, 16'h0000, 16'h8000, 1'b1,
             16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h4000, 1'b0);

    // Random stream with random bubbles and back-pressure.
    @(posedge clk); #1;
    start = n_acc1;
    guard = 0;
    while ((n_acc1 - start) < 64 && guard < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      a_r = rand16(); a_i = rand16(); b_r = rand16(); b_i = rand16();
      conj_b = 1'($urandom_range(0, 1));
      guard++;
      @(posedge clk); #1;
    end
    check("stream.accepted", n_acc1 - start, 64);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stream.drain1", q1.size(), 0);
    check("stream.drain2", q2.size(), 0);
    check("stream.count1", n_pop1, n_acc1);
    check("stream.count2", n_pop2, n_acc2);

    // Reset with three samples in flight and the output stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_r = rand16(); a_i = rand16(); b_r = rand16(); b_i = rand16();
      conj_b = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.out_valid", {31'd0, out_valid1}, 32'd0);
    check("midrst.out_r",     {16'd0, out_r1}, 32'd0);
    check("midrst.out_i",     {16'd0, out_i1}, 32'd0);
    check("midrst.out_ovf",   {31'd0, out_ovf1}, 32'd0);
    check("midrst.in_ready",  {31'd0, in_ready1}, 32'd1);
    check("midrst.tw_valid",  {31'd0, out_valid2}, 32'd0);
    out_ready = 1'b1;
    a_r = 16'h2000; a_i = 16'hE000; b_r = 16'h6000; b_i = 16'h1000; conj_b = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid1) nv++;
      @(posedge clk); #1;
    end
    check("midrst.single_out", nv, 1);
    check("midrst.drain", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
